// File: rtl/rx_controller_pkg.sv
// Shared types and constants for the Ethernet receive controller.
package rx_controller_pkg;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_HEADER  = 2'd1,
    RX_PAYLOAD = 2'd2,
    RX_DROP    = 2'd3
  } rx_fsm;

  localparam int          ETH_HDR_BYTES = 14;
  localparam logic [3:0]  HDR_LAST_IDX  = 4'd13;
  localparam logic [15:0] ETH_TYPE_MIN  = 16'h0600;
  localparam logic [15:0] MAX_PAYLOAD   = 16'd1500;
  localparam logic [47:0] LOCAL_MAC     = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rx_controller_if.sv
// Byte stream from the MAC plus the write/commit/rewind port of the receive buffer.
// slave: the controller's view; master: the MAC/buffer side driving it.
interface rx_controller_if;
  logic [7:0] rx_axis_tdata;
  logic       rx_axis_tvalid;
  logic       rx_axis_tlast;
  logic       rx_axis_tuser;
  logic       brx_full;
  logic       brx_wr_en;
  logic [7:0] brx_wr_data;
  logic       brx_commit;
  logic       brx_rewind;

  modport slave (
    input  rx_axis_tdata, rx_axis_tvalid, rx_axis_tlast, rx_axis_tuser, brx_full,
    output brx_wr_en, brx_wr_data, brx_commit, brx_rewind
  );

  modport master (
    output rx_axis_tdata, rx_axis_tvalid, rx_axis_tlast, rx_axis_tuser, brx_full,
    input  brx_wr_en, brx_wr_data, brx_commit, brx_rewind
  );
endinterface

// File: rtl/rx_controller_header_shift.sv
// Header capture: each header byte lands in the slot named by its byte index,
// so fields only change as the next frame's header bytes arrive.
module rx_header_shift
  import rx_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cap_en,
  input  logic [3:0]  cap_idx,
  input  logic [7:0]  cap_byte,
  output logic [47:0] hdr_dst,
  output logic [47:0] hdr_src,
  output logic [15:0] hdr_type
);

  logic [7:0] byte_q [ETH_HDR_BYTES];
  logic [7:0] byte_d [ETH_HDR_BYTES];

  // Steer the incoming byte into the slot addressed by its header index.
  always_comb begin
    for (int i = 0; i < ETH_HDR_BYTES; i++) begin
      byte_d[i] = byte_q[i];
      if (cap_en && (cap_idx == 4'(i))) begin
        byte_d[i] = cap_byte;
      end
    end
  end

  // Header byte slots.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ETH_HDR_BYTES; i++) begin
        byte_q[i] <= 8'h00;
      end
    end else begin
      byte_q <= byte_d;
    end
  end

  // Bytes arrive MSB first: slot 0 is the top byte of the destination.
  for (genvar gi = 0; gi < 6; gi++) begin : g_mac
    assign hdr_dst[47-8*gi -: 8] = byte_q[gi];
    assign hdr_src[47-8*gi -: 8] = byte_q[6+gi];
  end

  assign hdr_type = {byte_q[12], byte_q[13]};

endmodule

// File: rtl/rx_controller.sv
// Ethernet receive controller: parses the 14-byte header, writes payload bytes
// into the receive buffer and closes each frame with a commit or a rewind.
// Optional destination filter enabled by defining RX_ADDR_FILTER_EN.
module rx_controller
  import rx_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  rx_controller_if.slave     bus,
  output logic [47:0]        hdr_dst,
  output logic [47:0]        hdr_src,
  output logic [15:0]        hdr_type,
  output logic               rx_header_valid,
  output logic [15:0]        frame_len,
  output logic [15:0]        drop_cnt
);

  rx_fsm       state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic [15:0] frame_len_q, frame_len_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic        beat;
  logic        last;
  logic        cap_en;
  logic [3:0]  cap_idx;
  logic        wr_en, commit, rewind, drop_evt, abort;
  logic [15:0] type_full;
  logic        type_bad;
  logic        type_is_len;
  logic [15:0] limit;
  logic        addr_ok;

  // Beats are ignored while reset is held so no buffer strobes escape.
  assign beat = bus.rx_axis_tvalid & rst_n;
  assign last = bus.rx_axis_tlast;

  assign cap_en  = beat && ((state_q == RX_IDLE) || (state_q == RX_HEADER));
  assign cap_idx = (state_q == RX_IDLE) ? 4'd0 : idx_q;

  rx_header_shift u_hdr (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap_en   (cap_en),
    .cap_idx  (cap_idx),
    .cap_byte (bus.rx_axis_tdata),
    .hdr_dst  (hdr_dst),
    .hdr_src  (hdr_src),
    .hdr_type (hdr_type)
  );

  // On byte 13 the type field is only complete once the live byte is appended.
  assign type_full = {hdr_type[15:8], bus.rx_axis_tdata};
  assign type_bad  = (type_full > MAX_PAYLOAD) && (type_full < ETH_TYPE_MIN);

  // Small type values are a length field: bytes past it are padding.
  assign type_is_len = (hdr_type <= MAX_PAYLOAD);
  assign limit       = type_is_len ? hdr_type : MAX_PAYLOAD;

`ifdef RX_ADDR_FILTER_EN
  assign addr_ok = (hdr_dst == LOCAL_MAC) || (hdr_dst == BROADCAST_MAC);
`else
  assign addr_ok = 1'b1;
`endif

  // Frame parser: next state, counters and the buffer control strobes.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    hdr_valid_d = 1'b0;
    frame_len_d = frame_len_q;
    wr_en       = 1'b0;
    commit      = 1'b0;
    rewind      = 1'b0;
    drop_evt    = 1'b0;
    abort       = 1'b0;
    if (beat) begin
      case (state_q)
        RX_IDLE: begin
          if (last) begin
            drop_evt = 1'b1;
          end else begin
            state_d = RX_HEADER;
            idx_d   = 4'd1;
          end
        end
        RX_HEADER: begin
          if (last) begin
            drop_evt = 1'b1;
            state_d  = RX_IDLE;
            idx_d    = 4'd0;
          end else if (idx_q == HDR_LAST_IDX) begin
            idx_d = 4'd0;
            if (!addr_ok || type_bad) begin
              drop_evt = 1'b1;
              state_d  = RX_DROP;
            end else begin
              hdr_valid_d = 1'b1;
              cnt_d       = 16'd0;
              state_d     = RX_PAYLOAD;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        RX_PAYLOAD: begin
          // Buffer overflow outranks everything else on this beat.
          if (bus.brx_full) begin
            abort = 1'b1;
          end else if (cnt_q < limit) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 16'd1;
          end else if (!type_is_len) begin
            abort = 1'b1;
          end
          if (abort) begin
            rewind   = 1'b1;
            drop_evt = 1'b1;
            state_d  = last ? RX_IDLE : RX_DROP;
          end else if (last) begin
            state_d = RX_IDLE;
            if (bus.rx_axis_tuser) begin
              rewind   = 1'b1;
              drop_evt = 1'b1;
            end else begin
              commit      = 1'b1;
              frame_len_d = cnt_d;
            end
          end
        end
        RX_DROP: begin
          if (last) begin
            state_d = RX_IDLE;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  assign drop_cnt_d = drop_evt ? sat_inc16(drop_cnt_q) : drop_cnt_q;

  // Parser state and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RX_IDLE;
      idx_q       <= 4'd0;
      cnt_q       <= 16'd0;
      hdr_valid_q <= 1'b0;
      frame_len_q <= 16'd0;
      drop_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      hdr_valid_q <= hdr_valid_d;
      frame_len_q <= frame_len_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.brx_wr_en   = wr_en;
  assign bus.brx_wr_data = bus.rx_axis_tdata;
  assign bus.brx_commit  = commit;
  assign bus.brx_rewind  = rewind;

  assign rx_header_valid = hdr_valid_q;
  assign frame_len       = frame_len_d;
  assign drop_cnt        = drop_cnt_q;

endmodule

// File: tb/tb_rx_controller.sv
// Scoreboard bench for rx_controller: each frame pushes its expected event
// sequence (header pulse, writes, commit/rewind, drop count) into a queue and
// a negedge monitor pops and compares every event the DUT produces.
module tb_rx_controller;
  import rx_controller_pkg::*;

  localparam logic [2:0] EV_HDR    = 3'd0;
  localparam logic [2:0] EV_WR     = 3'd1;
  localparam logic [2:0] EV_COMMIT = 3'd2;
  localparam logic [2:0] EV_REWIND = 3'd3;
  localparam logic [2:0] EV_DROP   = 3'd4;

  localparam logic [47:0] SRC_MAC   = 48'h0A_1B_2C_3D_4E_5F;
  localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_02;

  typedef struct packed {
    logic [2:0]   kind;
    logic [111:0] data;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic [47:0] hdr_dst, hdr_src;
  logic [15:0] hdr_type;
  logic        rx_header_valid;
  logic [15:0] frame_len;
  logic [15:0] drop_cnt;

  rx_controller_if bus ();

  rx_controller dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .hdr_dst         (hdr_dst),
    .hdr_src         (hdr_src),
    .hdr_type        (hdr_type),
    .rx_header_valid (rx_header_valid),
    .frame_len       (frame_len),
    .drop_cnt        (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ev_t  exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   exp_drop = 0;
  bit   gap_mode = 0;
  int   beat_cnt = 0;
  logic [15:0] last_drop;

  function automatic string kname(input logic [2:0] k);
    case (k)
      EV_HDR:    return "hdr";
      EV_WR:     return "write";
      EV_COMMIT: return "commit";
      EV_REWIND: return "rewind";
      EV_DROP:   return "drop_cnt";
      default:   return "?";
    endcase
  endfunction

  function automatic logic [7:0] pay_byte(input int i);
    return 8'((i * 5 + 17) & 255);
  endfunction

  task automatic push(input logic [2:0] k, input logic [111:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input logic [2:0] k, input logic [111:0] d);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got data %h, required no event", kname(k), d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.data != d) begin
        n_fail++;
        $display("FAIL event_%s: got %s data %h, required %s data %h",
                 kname(e.kind), kname(k), d, kname(e.kind), e.data);
      end
    end
  endtask

  task automatic check_eq(input string name, input logic [111:0] act, input logic [111:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: record every DUT event in a fixed intra-cycle order.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_drop = drop_cnt;
      end else begin
        if (rx_header_valid) observe(EV_HDR, {hdr_dst, hdr_src, hdr_type});
        if (bus.brx_wr_en)   observe(EV_WR, 112'(bus.brx_wr_data));
        if (bus.brx_commit)  observe(EV_COMMIT, 112'(frame_len));
        if (bus.brx_rewind)  observe(EV_REWIND, 112'(0));
        if (drop_cnt !== last_drop) observe(EV_DROP, 112'(drop_cnt));
        last_drop = drop_cnt;
      end
    end
  end

  // One beat: present it, let one rising edge consume it, then release.
  task automatic drive(input logic [7:0] d, input logic l, input logic u, input logic f);
    bus.rx_axis_tdata  = d;
    bus.rx_axis_tvalid = 1'b1;
    bus.rx_axis_tlast  = l;
    bus.rx_axis_tuser  = u;
    bus.brx_full       = f;
    @(posedge clk); #1;
    bus.rx_axis_tvalid = 1'b0;
    bus.rx_axis_tlast  = 1'b0;
    bus.rx_axis_tuser  = 1'b0;
    bus.brx_full       = 1'b0;
    beat_cnt++;
    if (gap_mode && (beat_cnt % 4 == 3)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    bus.rx_axis_tvalid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Send one frame and queue the hand-computed outcome:
  // e_hdr header pulse, e_wr writes, e_end 0 none/1 commit/2 rewind, e_drop.
  task automatic send_frame(input string tag, input logic [47:0] dst, input logic [15:0] typ,
                            input int npay, input logic user, input int full_at, input int runt_at,
                            input bit e_hdr, input int e_wr, input int e_end, input bit e_drop);
    logic [111:0] h;
    h = {dst, SRC_MAC, typ};
    if (e_hdr) push(EV_HDR, h);
    for (int i = 0; i < e_wr; i++) push(EV_WR, 112'(pay_byte(i)));
    if (e_end == 1) push(EV_COMMIT, 112'(e_wr));
    else if (e_end == 2) push(EV_REWIND, 112'(0));
    if (e_drop) begin
      exp_drop++;
      push(EV_DROP, 112'(exp_drop));
    end
    $display("frame %s: dst=%h type=%h payload=%0d expect writes=%0d end=%0d drop=%0d",
             tag, dst, typ, npay, e_wr, e_end, e_drop);
    for (int k = 0; k < ETH_HDR_BYTES; k++) begin
      drive(h[111-8*k -: 8], (k == runt_at), 1'b0, 1'b0);
      if (k == runt_at) return;
    end
    for (int i = 0; i < npay; i++) begin
      drive(pay_byte(i), (i == npay - 1), (i == npay - 1) ? user : 1'b0, (i == full_at));
    end
  endtask

  task automatic drain(input string name);
    idle(4);
    check_eq(name, 112'(exp_q.size()), 112'(0));
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got time limit reached, required end of stimulus");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    logic [111:0] h;
    rst_n              = 1'b0;
    bus.rx_axis_tdata  = 8'h00;
    bus.rx_axis_tvalid = 1'b0;
    bus.rx_axis_tlast  = 1'b0;
    bus.rx_axis_tuser  = 1'b0;
    bus.brx_full       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_hdr_dst", 112'(hdr_dst), 112'(0));
    check_eq("rst_hdr_src", 112'(hdr_src), 112'(0));
    check_eq("rst_hdr_type", 112'(hdr_type), 112'(0));
    check_eq("rst_hdr_valid", 112'(rx_header_valid), 112'(0));
    check_eq("rst_frame_len", 112'(frame_len), 112'(0));
    check_eq("rst_drop_cnt", 112'(drop_cnt), 112'(0));
    check_eq("rst_wr_en", 112'(bus.brx_wr_en), 112'(0));
    check_eq("rst_commit", 112'(bus.brx_commit), 112'(0));
    check_eq("rst_rewind", 112'(bus.brx_rewind), 112'(0));
    rst_n = 1'b1;
    idle(2);

    // Main path, back-to-back frames, length field padding.
    send_frame("ip46",      LOCAL_MAC, 16'h0800, 46, 1'b0, -1, -1, 1, 46, 1, 0);
    send_frame("len5",      LOCAL_MAC, 16'h0005, 46, 1'b0, -1, -1, 1, 5, 1, 0);
    send_frame("tuser100",  LOCAL_MAC, 16'h0800, 100, 1'b1, -1, -1, 1, 100, 2, 1);
    send_frame("full_at10", LOCAL_MAC, 16'h0800, 64, 1'b0, 10, -1, 1, 10, 2, 1);
    send_frame("after_ovf", LOCAL_MAC, 16'h0800, 30, 1'b0, -1, -1, 1, 30, 1, 0);
    drain("drain_basic");

    // Runts at header byte 8, 0 and 13.
    send_frame("runt8",  LOCAL_MAC, 16'h0800, 0, 1'b0, -1, 8, 0, 0, 0, 1);
    send_frame("runt0",  LOCAL_MAC, 16'h0800, 0, 1'b0, -1, 0, 0, 0, 0, 1);
    send_frame("runt13", LOCAL_MAC, 16'h0800, 0, 1'b0, -1, 13, 0, 0, 0, 1);
    // Malformed length fields just above the limit and just below ethertypes.
    send_frame("bad05DD", LOCAL_MAC, 16'h05DD, 20, 1'b0, -1, -1, 0, 0, 0, 1);
    send_frame("bad05FF", LOCAL_MAC, 16'h05FF, 20, 1'b0, -1, -1, 0, 0, 0, 1);
    drain("drain_runt");

    // Type boundaries and zero/maximum length fields, with idle gaps mid-frame.
    gap_mode = 1;
    send_frame("type0600", LOCAL_MAC, 16'h0600, 20, 1'b0, -1, -1, 1, 20, 1, 0);
    send_frame("len1500",  LOCAL_MAC, 16'd1500, 10, 1'b0, -1, -1, 1, 10, 1, 0);
    send_frame("len0",     LOCAL_MAC, 16'h0000, 46, 1'b0, -1, -1, 1, 0, 1, 0);
    gap_mode = 0;
    send_frame("eth1500",  LOCAL_MAC, 16'h0800, 1500, 1'b0, -1, -1, 1, 1500, 1, 0);
    send_frame("eth1501",  LOCAL_MAC, 16'h0800, 1501, 1'b0, -1, -1, 1, 1500, 2, 1);
    drain("drain_limits");

    // Destination filter.
`ifdef RX_ADDR_FILTER_EN
    send_frame("dst_other", OTHER_MAC, 16'h0800, 20, 1'b0, -1, -1, 0, 0, 0, 1);
`else
    send_frame("dst_other", OTHER_MAC, 16'h0800, 20, 1'b0, -1, -1, 1, 20, 1, 0);
`endif
    send_frame("dst_bcast", BROADCAST_MAC, 16'h0800, 20, 1'b0, -1, -1, 1, 20, 1, 0);
    drain("drain_filter");

    // Reset mid-payload: no commit or rewind, tail parsed as a new (runt) frame.
    $display("frame midreset: header + 5 payload, reset, 10-beat tail");
    h = {LOCAL_MAC, SRC_MAC, 16'h0800};
    push(EV_HDR, h);
    for (int i = 0; i < 5; i++) push(EV_WR, 112'(pay_byte(i)));
    for (int k = 0; k < ETH_HDR_BYTES; k++) drive(h[111-8*k -: 8], 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(pay_byte(i), 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("midrst_drop_cnt", 112'(drop_cnt), 112'(0));
    check_eq("midrst_hdr_type", 112'(hdr_type), 112'(0));
    rst_n    = 1'b1;
    exp_drop = 0;
    exp_drop++;
    push(EV_DROP, 112'(exp_drop));
    for (int i = 5; i < 15; i++) drive(pay_byte(i), (i == 14), 1'b0, 1'b0);
    send_frame("post_rst", LOCAL_MAC, 16'h0800, 12, 1'b0, -1, -1, 1, 12, 1, 0);
    drain("drain_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
